// File: rtl/alu_result_stage_if.sv
// Handshake and data bundle between the ALU, the result stage and the memory stage.
// The slave modport is the result stage's view; master is the surrounding pipeline's view.
interface alu_result_stage_if #(
    parameter int DW = 32,
    parameter int RW = 5
);
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] alu_out;
    logic          alu_zero;
    logic          alu_negative;
    logic          alu_overflow;
    logic          ovf_trap_en;
    logic [RW-1:0] rd;
    logic          regwr;
    logic [DW-1:0] inst_pc;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_zero;
    logic          out_negative;
    logic [RW-1:0] out_rd;
    logic          out_regwr;
    logic          exc_pulse;
    logic [DW-1:0] exc_pc;

    modport slave (
        input  in_valid, alu_out, alu_zero, alu_negative, alu_overflow,
               ovf_trap_en, rd, regwr, inst_pc, flush, out_ready,
        output in_ready, out_valid, out_data, out_zero, out_negative,
               out_rd, out_regwr, exc_pulse, exc_pc
    );

    modport master (
        output in_valid, alu_out, alu_zero, alu_negative, alu_overflow,
               ovf_trap_en, rd, regwr, inst_pc, flush, out_ready,
        input  in_ready, out_valid, out_data, out_zero, out_negative,
               out_rd, out_regwr, exc_pulse, exc_pc
    );
endinterface

// File: rtl/alu_result_stage.sv
// Two-entry result buffer behind the ALU with overflow-trap strobe and a short issue lockout.
// All outputs, including in_ready, come straight from flops.
module alu_result_stage #(
    parameter int DW          = 32,
    parameter int RW          = 5,
    parameter int TRAP_CYCLES = 2
) (
    input  logic              CLK,
    input  logic              nRST,
    alu_result_stage_if.slave bus
);
    typedef enum logic [0:0] {ST_NORMAL = 1'b0, ST_TRAP = 1'b1} state_t;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          zero;
        logic          neg;
        logic [RW-1:0] rd;
        logic          regwr;
    } entry_t;

    localparam logic [3:0] TRAP_INIT = 4'(TRAP_CYCLES);

    state_t        state_r, state_nxt_s;
    logic [3:0]    trap_cnt_r, trap_cnt_nxt_s;
    logic [1:0]    count_r, count_nxt_s;
    entry_t        head_r, head_nxt_s;
    entry_t        tail_r, tail_nxt_s;
    entry_t        in_entry_s;
    logic          in_ready_r;
    logic          out_valid_r;
    logic          exc_pulse_r;
    logic [DW-1:0] exc_pc_r;
    logic          acc_s;
    logic          deq_s;
    logic          ovf_s;
    logic          trap_s;

    assign acc_s  = bus.in_valid && in_ready_r;
    assign deq_s  = out_valid_r && bus.out_ready;
    assign ovf_s  = bus.ovf_trap_en && bus.alu_overflow;
    // A flushed transfer is discarded, so it must not raise a trap either.
    assign trap_s = acc_s && ovf_s && !bus.flush;

    assign in_entry_s.data  = bus.alu_out;
    assign in_entry_s.zero  = bus.alu_zero;
    assign in_entry_s.neg   = bus.alu_negative;
    assign in_entry_s.rd    = bus.rd;
    assign in_entry_s.regwr = bus.regwr && !ovf_s;

    // Trap lockout FSM: next state and counter.
    always_comb begin
        state_nxt_s    = state_r;
        trap_cnt_nxt_s = trap_cnt_r;
        if (bus.flush) begin
            state_nxt_s    = ST_NORMAL;
            trap_cnt_nxt_s = 4'd0;
        end else begin
            case (state_r)
                ST_NORMAL: begin
                    if (trap_s) begin
                        state_nxt_s    = ST_TRAP;
                        trap_cnt_nxt_s = TRAP_INIT;
                    end else begin
                        state_nxt_s    = ST_NORMAL;
                        trap_cnt_nxt_s = 4'd0;
                    end
                end
                ST_TRAP: begin
                    if (trap_cnt_r <= 4'd1) begin
                        state_nxt_s    = ST_NORMAL;
                        trap_cnt_nxt_s = 4'd0;
                    end else begin
                        state_nxt_s    = ST_TRAP;
                        trap_cnt_nxt_s = trap_cnt_r - 4'd1;
                    end
                end
                default: begin
                    state_nxt_s    = ST_NORMAL;
                    trap_cnt_nxt_s = 4'd0;
                end
            endcase
        end
    end

    // FIFO next-state: head/tail contents and occupancy.
    always_comb begin
        head_nxt_s  = head_r;
        tail_nxt_s  = tail_r;
        count_nxt_s = count_r;
        if (bus.flush) begin
            count_nxt_s = 2'd0;
        end else begin
            case ({acc_s, deq_s})
                2'b10: begin
                    if (count_r == 2'd0) begin
                        head_nxt_s = in_entry_s;
                    end else begin
                        tail_nxt_s = in_entry_s;
                    end
                    count_nxt_s = count_r + 2'd1;
                end
                2'b01: begin
                    head_nxt_s  = tail_r;
                    count_nxt_s = count_r - 2'd1;
                end
                2'b11: begin
                    // Occupancy stays put; the new entry queues behind whatever remains.
                    if (count_r == 2'd2) begin
                        head_nxt_s = tail_r;
                        tail_nxt_s = in_entry_s;
                    end else begin
                        head_nxt_s = in_entry_s;
                    end
                end
                default: begin
                    count_nxt_s = count_r;
                end
            endcase
        end
    end

    // State, storage and registered outputs.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_r     <= ST_NORMAL;
            trap_cnt_r  <= 4'd0;
            count_r     <= 2'd0;
            head_r      <= '0;
            tail_r      <= '0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            exc_pulse_r <= 1'b0;
            exc_pc_r    <= '0;
        end else begin
            state_r     <= state_nxt_s;
            trap_cnt_r  <= trap_cnt_nxt_s;
            count_r     <= count_nxt_s;
            head_r      <= head_nxt_s;
            tail_r      <= tail_nxt_s;
            in_ready_r  <= (count_nxt_s != 2'd2) && (state_nxt_s == ST_NORMAL);
            out_valid_r <= (count_nxt_s != 2'd0);
            exc_pulse_r <= trap_s;
            if (trap_s) begin
                exc_pc_r <= bus.inst_pc;
            end else begin
                exc_pc_r <= exc_pc_r;
            end
        end
    end

    assign bus.in_ready     = in_ready_r;
    assign bus.out_valid    = out_valid_r;
    assign bus.out_data     = head_r.data;
    assign bus.out_zero     = head_r.zero;
    assign bus.out_negative = head_r.neg;
    assign bus.out_rd       = head_r.rd;
    assign bus.out_regwr    = head_r.regwr;
    assign bus.exc_pulse    = exc_pulse_r;
    assign bus.exc_pc       = exc_pc_r;
endmodule

// File: tb/tb_alu_result_stage.sv
// Scoreboard bench for alu_result_stage: a reference model tracks queue contents,
// trap lockout and exception strobe, and every output is compared each cycle.
module tb_alu_result_stage;
    localparam int DW = 32;
    localparam int RW = 5;
    localparam int TC = 2;

    logic CLK  = 1'b0;
    logic nRST = 1'b1;
    always #5 CLK = ~CLK;

    alu_result_stage_if #(.DW(DW), .RW(RW)) bus ();
    alu_result_stage #(.DW(DW), .RW(RW), .TRAP_CYCLES(TC)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    int          chk_cnt   = 0;
    int          pass_cnt  = 0;
    logic [39:0] exp_q[$];
    int          trap_left = 0;
    logic        exc_exp   = 1'b0;
    logic [31:0] pc_exp    = 32'd0;
    logic        m_ready, m_acc, m_deq, m_trp;
    logic [39:0] m_head;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        chk_cnt++;
        if (obs === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Reference model: compare outputs, then apply this cycle's transfers for the next edge.
    always @(negedge CLK) begin
        if (!nRST) begin
            exp_q.delete();
            trap_left = 0;
            exc_exp   = 1'b0;
            pc_exp    = 32'd0;
        end else begin
            m_ready = (exp_q.size() < 2) && (trap_left == 0);
            check_val("out_valid", bus.out_valid, exp_q.size() != 0);
            check_val("in_ready", bus.in_ready, m_ready);
            check_val("exc_pulse", bus.exc_pulse, exc_exp);
            check_val("exc_pc", bus.exc_pc, pc_exp);
            m_acc = bus.in_valid && m_ready;
            m_deq = (exp_q.size() != 0) && bus.out_ready;
            if (m_deq) begin
                m_head = exp_q.pop_front();
                check_val("head", {bus.out_data, bus.out_zero, bus.out_negative,
                                   bus.out_rd, bus.out_regwr}, m_head);
            end
            m_trp   = m_acc && bus.ovf_trap_en && bus.alu_overflow && !bus.flush;
            exc_exp = m_trp;
            if (m_trp) pc_exp = bus.inst_pc;
            if (bus.flush) begin
                exp_q.delete();
                trap_left = 0;
            end else begin
                if (m_acc)
                    exp_q.push_back({bus.alu_out, bus.alu_zero, bus.alu_negative, bus.rd,
                                     bus.regwr && !(bus.ovf_trap_en && bus.alu_overflow)});
                if (m_trp) trap_left = TC;
                else if (trap_left > 0) trap_left--;
            end
        end
    end

    task automatic drive(input logic [31:0] d, input logic [4:0] r, input logic wr,
                         input logic ovf, input logic te, input logic [31:0] pc);
        bus.in_valid     = 1'b1;
        bus.alu_out      = d;
        bus.alu_zero     = (d == 32'd0);
        bus.alu_negative = d[31];
        bus.alu_overflow = ovf;
        bus.ovf_trap_en  = te;
        bus.rd           = r;
        bus.regwr        = wr;
        bus.inst_pc      = pc;
    endtask

    task automatic wait_accept();
        logic rdy;
        rdy = 1'b0;
        for (int n = 0; n < 50 && !rdy; n++) begin
            @(negedge CLK);
            rdy = bus.in_ready;
            @(posedge CLK);
            #1;
        end
        check_val("accept_wait", rdy, 1'b1);
        bus.in_valid = 1'b0;
    endtask

    task automatic send(input logic [31:0] d, input logic [4:0] r, input logic wr,
                        input logic ovf, input logic te, input logic [31:0] pc);
        drive(d, r, wr, ovf, te, pc);
        wait_accept();
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check_val({tag, "_out_valid"}, bus.out_valid, 1'b0);
        check_val({tag, "_out_data"}, bus.out_data, 32'd0);
        check_val({tag, "_out_flags"}, {bus.out_zero, bus.out_negative, bus.out_regwr}, 3'd0);
        check_val({tag, "_out_rd"}, bus.out_rd, 5'd0);
        check_val({tag, "_exc_pulse"}, bus.exc_pulse, 1'b0);
        check_val({tag, "_exc_pc"}, bus.exc_pc, 32'd0);
        check_val({tag, "_in_ready"}, bus.in_ready, 1'b1);
    endtask

    initial begin
        bus.in_valid = 1'b0; bus.alu_out = 32'd0; bus.alu_zero = 1'b0;
        bus.alu_negative = 1'b0; bus.alu_overflow = 1'b0; bus.ovf_trap_en = 1'b0;
        bus.rd = 5'd0; bus.regwr = 1'b0; bus.inst_pc = 32'd0; bus.flush = 1'b0;
        bus.out_ready = 1'b0;
        #1 nRST = 1'b0;
        idle(2);
        check_reset_vals("rst");
        nRST = 1'b1;

        // Single result, empty FIFO: visible right after the accepting edge.
        bus.out_ready = 1'b1;
        send(32'h0000_0005, 5'd3, 1'b1, 1'b0, 1'b0, 32'h10);
        check_val("lat_valid", bus.out_valid, 1'b1);
        check_val("lat_data", bus.out_data, 32'h5);
        check_val("lat_rd", bus.out_rd, 5'd3);
        idle(2);

        // Backpressure: two accepted, third held upstream until the consumer drains.
        bus.out_ready = 1'b0;
        send(32'hA, 5'd1, 1'b1, 1'b0, 1'b0, 32'h20);
        send(32'hB, 5'd2, 1'b1, 1'b0, 1'b0, 32'h24);
        drive(32'hC, 5'd4, 1'b1, 1'b0, 1'b0, 32'h28);
        idle(3);
        check_val("bp_hold", bus.in_ready, 1'b0);
        bus.out_ready = 1'b1;
        wait_accept();
        idle(4);

        // Signed overflow trap.
        send(32'h8000_0000, 5'd7, 1'b1, 1'b1, 1'b1, 32'h40);
        check_val("trap_exc", bus.exc_pulse, 1'b1);
        check_val("trap_pc", bus.exc_pc, 32'h40);
        check_val("trap_regwr", bus.out_regwr, 1'b0);
        check_val("trap_rdy0", bus.in_ready, 1'b0);
        idle(1);
        check_val("trap_rdy1", bus.in_ready, 1'b0);
        check_val("trap_exc_end", bus.exc_pulse, 1'b0);
        idle(1);
        check_val("trap_rdy2", bus.in_ready, 1'b1);

        // Unsigned overflow: no trap, writeback kept.
        send(32'h0000_0001, 5'd8, 1'b1, 1'b1, 1'b0, 32'h44);
        check_val("uns_exc", bus.exc_pulse, 1'b0);
        check_val("uns_regwr", bus.out_regwr, 1'b1);
        idle(2);

        // Flush with a full FIFO and a trapping input offered.
        bus.out_ready = 1'b0;
        send(32'h1, 5'd9, 1'b1, 1'b0, 1'b0, 32'h50);
        send(32'h2, 5'd10, 1'b1, 1'b0, 1'b0, 32'h54);
        drive(32'h8000_0000, 5'd11, 1'b1, 1'b1, 1'b1, 32'h58);
        bus.flush = 1'b1;
        idle(1);
        bus.flush = 1'b0; bus.in_valid = 1'b0;
        check_val("fl2_valid", bus.out_valid, 1'b0);
        check_val("fl2_ready", bus.in_ready, 1'b1);
        check_val("fl2_exc", bus.exc_pulse, 1'b0);

        // Flush while a trapping input is actually being accepted.
        send(32'h3, 5'd12, 1'b1, 1'b0, 1'b0, 32'h60);
        drive(32'h8000_0000, 5'd13, 1'b1, 1'b1, 1'b1, 32'h64);
        bus.flush = 1'b1;
        idle(1);
        bus.flush = 1'b0; bus.in_valid = 1'b0;
        check_val("fl1_exc", bus.exc_pulse, 1'b0);
        check_val("fl1_ready", bus.in_ready, 1'b1);
        check_val("fl1_valid", bus.out_valid, 1'b0);

        // Flush during the trap lockout.
        bus.out_ready = 1'b1;
        send(32'h8000_0001, 5'd14, 1'b1, 1'b1, 1'b1, 32'h80);
        bus.flush = 1'b1;
        idle(1);
        bus.flush = 1'b0;
        check_val("flt_ready", bus.in_ready, 1'b1);
        check_val("flt_pc", bus.exc_pc, 32'h80);
        idle(2);

        // Asynchronous reset while holding one entry in TRAP.
        bus.out_ready = 1'b0;
        send(32'h8000_0002, 5'd15, 1'b1, 1'b1, 1'b1, 32'hC0);
        #2 nRST = 1'b0;
        #1 check_reset_vals("arst");
        idle(1);
        nRST = 1'b1;
        bus.out_ready = 1'b1;
        send(32'h1234, 5'd9, 1'b1, 1'b0, 1'b0, 32'hD0);
        check_val("post_rst_data", bus.out_data, 32'h1234);
        idle(2);

        // Throughput: back-to-back results with the consumer always ready.
        for (int i = 0; i < 6; i++)
            send(32'h100 + 32'(i), 5'(i + 16), i[0], 1'b0, 1'b0, 32'h200 + 32'(4 * i));
        for (int n = 0; n < 20 && exp_q.size() != 0; n++) idle(1);
        idle(1);
        check_val("drain", exp_q.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
